// File: rtl/nvdla_rdma_reg_pkg.sv
// Shared definitions for the RDMA single-register slice: offsets, group status
// encoding and ERR register field positions.
package nvdla_rdma_reg_pkg;

  localparam logic [11:0] RDMA_S_STATUS      = 12'h000;
  localparam logic [11:0] RDMA_S_POINTER     = 12'h004;
  localparam logic [11:0] RDMA_S_INTR_MASK   = 12'h008;
  localparam logic [11:0] RDMA_S_INTR_STATUS = 12'h00C;
  localparam logic [11:0] RDMA_S_ERR         = 12'h010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PENDING = 2'd2
  } rdma_status_e;

  localparam int ERR_RO_BIT    = 0;
  localparam int ERR_UNDEF_BIT = 1;
  localparam int ERR_OFF_LSB   = 16;
  localparam int ERR_OFF_MSB   = 27;
  localparam int CONSUMER_LSB  = 16;

endpackage

// File: rtl/nvdla_rdma_intr_tracker.sv
// Per-group completion detection (RUNNING -> IDLE), masked W1C pending bits and
// the registered level interrupt.
module nvdla_rdma_intr_tracker
  import nvdla_rdma_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2*NUM_GROUPS-1:0] status_i,
  input  logic                    mask_wr_i,
  input  logic                    pend_w1c_i,
  input  logic [NUM_GROUPS-1:0]   wr_data_i,
  output logic [NUM_GROUPS-1:0]   mask_o,
  output logic [NUM_GROUPS-1:0]   pending_o,
  output logic                    intr_o
);

  logic [2*NUM_GROUPS-1:0] status_prev_q;
  logic [NUM_GROUPS-1:0]   mask_q, mask_d;
  logic [NUM_GROUPS-1:0]   pending_q, pending_d;
  logic [NUM_GROUPS-1:0]   done;
  logic [NUM_GROUPS-1:0]   clr;
  logic                    intr_q, intr_d;

  always_comb begin
    done = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      done[g] = (status_prev_q[2*g +: 2] == RUNNING) && (status_i[2*g +: 2] == IDLE);
    end
    mask_d    = mask_wr_i ? wr_data_i : mask_q;
    clr       = pend_w1c_i ? wr_data_i : '0;
    // A hardware completion in the same cycle as a W1C on that bit wins.
    pending_d = (pending_q & ~clr) | done;
    intr_d    = |(pending_q & mask_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_prev_q <= '0;
      mask_q        <= '0;
      pending_q     <= '0;
      intr_q        <= 1'b0;
    end else begin
      status_prev_q <= status_i;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
      intr_q        <= intr_d;
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign intr_o    = intr_q;

endmodule

// File: rtl/nvdla_rdma_reg_single_multi.sv
// Shared RDMA register slice: address decode, producer pointer, sticky ERR
// capture and the zero-latency read mux; interrupt state lives in the tracker.
module nvdla_rdma_reg_single_multi
  import nvdla_rdma_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic [11:0]                   reg_offset,
  input  logic [31:0]                   reg_wr_data,
  input  logic                          reg_wr_en,
  output logic [31:0]                   reg_rd_data,
  input  logic [$clog2(NUM_GROUPS)-1:0] consumer,
  input  logic [2*NUM_GROUPS-1:0]       status,
  output logic [$clog2(NUM_GROUPS)-1:0] producer,
  output logic                          intr
);

  localparam int PTR_W = $clog2(NUM_GROUPS);

  logic [PTR_W-1:0]      producer_q, producer_d;
  logic [1:0]            err_bits_q, err_bits_d;
  logic [11:0]           err_off_q, err_off_d;
  logic [1:0]            err_set;
  logic                  mask_wr, pend_w1c;
  logic [NUM_GROUPS-1:0] mask, pending;
  logic                  unused_wr_bits;

  assign unused_wr_bits = ^reg_wr_data;

  always_comb begin
    producer_d = producer_q;
    err_bits_d = err_bits_q;
    err_off_d  = err_off_q;
    err_set    = '0;
    mask_wr    = 1'b0;
    pend_w1c   = 1'b0;
    if (reg_wr_en) begin
      case (reg_offset)
        RDMA_S_STATUS:      err_set[ERR_RO_BIT] = 1'b1;
        RDMA_S_POINTER:     producer_d = reg_wr_data[PTR_W-1:0];
        RDMA_S_INTR_MASK:   mask_wr = 1'b1;
        RDMA_S_INTR_STATUS: pend_w1c = 1'b1;
        RDMA_S_ERR: begin
          err_bits_d = err_bits_q & ~reg_wr_data[1:0];
          if (err_bits_d == 2'b00) err_off_d = '0;
        end
        default:            err_set[ERR_UNDEF_BIT] = 1'b1;
      endcase
    end
    // Only the first offending offset is kept until software clears ERR.
    if (err_set != 2'b00) begin
      if (err_bits_q == 2'b00) err_off_d = reg_offset;
      err_bits_d = err_bits_q | err_set;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      producer_q <= '0;
      err_bits_q <= '0;
      err_off_q  <= '0;
    end else begin
      producer_q <= producer_d;
      err_bits_q <= err_bits_d;
      err_off_q  <= err_off_d;
    end
  end

  nvdla_rdma_intr_tracker #(
    .NUM_GROUPS(NUM_GROUPS)
  ) u_intr_tracker (
    .clk_i      (nvdla_core_clk),
    .rst_i      (nvdla_core_rst),
    .status_i   (status),
    .mask_wr_i  (mask_wr),
    .pend_w1c_i (pend_w1c),
    .wr_data_i  (reg_wr_data[NUM_GROUPS-1:0]),
    .mask_o     (mask),
    .pending_o  (pending),
    .intr_o     (intr)
  );

  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      RDMA_S_STATUS:      reg_rd_data[2*NUM_GROUPS-1:0] = status;
      RDMA_S_POINTER: begin
        reg_rd_data[PTR_W-1:0]             = producer_q;
        reg_rd_data[CONSUMER_LSB +: PTR_W] = consumer;
      end
      RDMA_S_INTR_MASK:   reg_rd_data[NUM_GROUPS-1:0] = mask;
      RDMA_S_INTR_STATUS: reg_rd_data[NUM_GROUPS-1:0] = pending;
      RDMA_S_ERR: begin
        reg_rd_data[1:0]                     = err_bits_q;
        reg_rd_data[ERR_OFF_MSB:ERR_OFF_LSB] = err_off_q;
      end
      default:            reg_rd_data = '0;
    endcase
  end

  assign producer = producer_q;

endmodule

// File: tb/tb_nvdla_rdma_reg_single_multi.sv
// Randomised bench for the RDMA register slice with NUM_GROUPS=4: a per-cycle
// reference model predicts {intr, producer, reg_rd_data}; a monitor checks them.
module tb_nvdla_rdma_reg_single_multi;

  localparam int NG = 4;
  localparam int OW = 35;

  logic        clk;
  logic        rst;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic [1:0]  consumer;
  logic [7:0]  status;
  logic [1:0]  producer;
  logic        intr;

  nvdla_rdma_reg_single_multi #(
    .NUM_GROUPS(NG)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .reg_offset     (reg_offset),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .reg_rd_data    (reg_rd_data),
    .consumer       (consumer),
    .status         (status),
    .producer       (producer),
    .intr           (intr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [OW-1:0] exp_q[$];
  string         name_q[$];
  int            tests_run = 0;
  int            fails = 0;
  logic          chk_en = 1'b0;

  // reference model state
  logic [1:0]  m_producer;
  logic [3:0]  m_mask;
  logic [3:0]  m_pending;
  logic [1:0]  m_err_bits;
  logic [11:0] m_err_off;
  logic        m_intr;
  int          m_prev[NG];

  function automatic int grp(input logic [7:0] st, input int g);
    return int'((st >> (2*g)) & 8'h3);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] off, input logic [7:0] st,
                                             input logic [1:0] cons);
    logic [31:0] r;
    case (off)
      12'h000: r = {24'b0, st};
      12'h004: r = {14'b0, cons, 14'b0, m_producer};
      12'h008: r = {28'b0, m_mask};
      12'h00C: r = {28'b0, m_pending};
      12'h010: r = {4'b0, m_err_off, 14'b0, m_err_bits};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [11:0] off,
                              input logic [31:0] d, input logic [7:0] st);
    logic       old_or;
    logic [1:0] newerr;
    if (r) begin
      m_producer = 0; m_mask = 0; m_pending = 0; m_err_bits = 0; m_err_off = 0; m_intr = 0;
      for (int g = 0; g < NG; g++) m_prev[g] = 0;
      return;
    end
    old_or = |(m_pending & m_mask);
    for (int g = 0; g < NG; g++) begin
      if (m_prev[g] == 1 && grp(st, g) == 0) m_pending[g] = 1'b1;
      else if (w && off == 12'h00C && d[g]) m_pending[g] = 1'b0;
    end
    newerr = 2'b00;
    if (w) begin
      if (off == 12'h000) newerr = 2'b01;
      else if (off == 12'h004) m_producer = d[1:0];
      else if (off == 12'h008) m_mask = d[3:0];
      else if (off == 12'h00C) begin end
      else if (off == 12'h010) begin
        m_err_bits = m_err_bits & ~d[1:0];
        if (m_err_bits == 0) m_err_off = 0;
      end else newerr = 2'b10;
    end
    if (newerr != 0) begin
      if (m_err_bits == 0) m_err_off = off;
      m_err_bits = m_err_bits | newerr;
    end
    m_intr = old_or;
    for (int g = 0; g < NG; g++) m_prev[g] = grp(st, g);
  endtask

  // driver: apply one cycle of inputs, predict outputs, advance the model
  task automatic step(input logic r, input logic w, input logic [11:0] off, input logic [31:0] d,
                      input logic [7:0] st, input logic [1:0] cons, input string nm,
                      input logic do_chk = 1'b1);
    rst = r; reg_wr_en = w; reg_offset = off; reg_wr_data = d; status = st; consumer = cons;
    chk_en = do_chk;
    if (do_chk) begin
      exp_q.push_back({m_intr, m_producer, model_read(off, st, cons)});
      name_q.push_back(nm);
    end
    @(posedge clk);
    model_update(r, w, off, d, st);
    #1;
  endtask

  task automatic rd(input logic [11:0] off, input logic [7:0] st, input logic [1:0] cons,
                    input string nm);
    step(1'b0, 1'b0, off, 32'h0, st, cons, nm);
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [7:0] st,
                    input string nm);
    step(1'b0, 1'b1, off, d, st, 2'd0, nm);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [OW-1:0] obs, e;
    string nm;
    if (chk_en) begin
      obs = {intr, producer, reg_rd_data};
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL underflow: got %h with no expected entry", obs);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (obs !== e) begin
          fails++;
          $display("FAIL %s @%0t: got intr=%b producer=%0d rd=%h, expected intr=%b producer=%0d rd=%h",
                   nm, $time, obs[34], obs[33:32], obs[31:0], e[34], e[33:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [7:0] rand_status();
    logic [7:0] s;
    int r;
    s = '0;
    for (int g = 0; g < NG; g++) begin
      r = $urandom_range(0, 7);
      if (r <= 3) s[2*g +: 2] = 2'd0;
      else if (r <= 6) s[2*g +: 2] = 2'd1;
      else s[2*g +: 2] = 2'($urandom_range(2, 3));
    end
    return s;
  endfunction

  function automatic logic [11:0] rand_offset();
    int p;
    logic [11:0] o;
    p = $urandom_range(0, 6);
    case (p)
      0: o = 12'h000;
      1: o = 12'h004;
      2: o = 12'h008;
      3: o = 12'h00C;
      4: o = 12'h010;
      5: o = 12'($urandom_range(0, 4095));
      default: o = 12'($urandom_range(5, 1023) * 4);
    endcase
    return o;
  endfunction

  initial begin
    rst = 1'b1; reg_wr_en = 1'b0; reg_offset = '0; reg_wr_data = '0; status = '0; consumer = '0;
    for (int g = 0; g < NG; g++) m_prev[g] = 0;
    m_producer = 0; m_mask = 0; m_pending = 0; m_err_bits = 0; m_err_off = 0; m_intr = 0;
    @(posedge clk); #1;

    // reset, then all offsets read zero
    step(1'b1, 1'b0, 12'h000, 32'h0, 8'h00, 2'd0, "reset_first", 1'b0);
    step(1'b1, 1'b0, 12'h000, 32'h0, 8'h00, 2'd0, "reset_hold");
    rd(12'h000, 8'h00, 2'd0, "rst_status");
    rd(12'h004, 8'h00, 2'd0, "rst_pointer");
    rd(12'h008, 8'h00, 2'd0, "rst_mask");
    rd(12'h00C, 8'h00, 2'd0, "rst_pending");
    rd(12'h010, 8'h00, 2'd0, "rst_err");

    // pointer write: consumer bits ignored
    wr(12'h004, 32'hFFFF_0003, 8'h00, "ptr_wr");
    rd(12'h004, 8'h00, 2'd2, "ptr_rd");
    rd(12'h010, 8'h00, 2'd2, "ptr_err_clean");

    // read-only write then undefined write: first offset kept
    wr(12'h000, 32'h1, 8'h00, "ro_wr");
    wr(12'h040, 32'h5, 8'h00, "undef_wr");
    rd(12'h010, 8'h00, 2'd0, "err_rd");
    wr(12'h010, 32'h3, 8'h00, "err_w1c");
    rd(12'h010, 8'h00, 2'd0, "err_cleared");

    // mask group1, group1 completes
    wr(12'h008, 32'h2, 8'h00, "mask_wr");
    rd(12'h00C, 8'h04, 2'd0, "g1_running");
    rd(12'h00C, 8'h00, 2'd0, "g1_done_edge");
    rd(12'h00C, 8'h00, 2'd0, "g1_pending");
    rd(12'h00C, 8'h00, 2'd0, "g1_intr");
    // group0 completes, masked off
    rd(12'h00C, 8'h01, 2'd0, "g0_running");
    rd(12'h00C, 8'h00, 2'd0, "g0_done_edge");
    rd(12'h00C, 8'h00, 2'd0, "g0_pending");

    // set beats W1C in the same cycle
    rd(12'h00C, 8'h04, 2'd0, "g1_run_again");
    wr(12'h00C, 32'h2, 8'h00, "w1c_vs_set");
    rd(12'h00C, 8'h00, 2'd0, "set_wins");
    wr(12'h00C, 32'h2, 8'h00, "w1c_alone");
    rd(12'h00C, 8'h00, 2'd0, "w1c_cleared");
    rd(12'h00C, 8'h00, 2'd0, "intr_fall");
    // glitch and non-completions
    rd(12'h00C, 8'h04, 2'd0, "glitch_a");
    rd(12'h00C, 8'h00, 2'd0, "glitch_b");
    rd(12'h00C, 8'h04, 2'd0, "glitch_c");
    rd(12'h00C, 8'h80, 2'd0, "pend_state");
    rd(12'h00C, 8'h00, 2'd0, "pending_to_idle");

    // mid-run reset with all pending and producer=3; the write is dropped
    wr(12'h004, 32'h3, 8'h55, "prod3");
    wr(12'h008, 32'hF, 8'h00, "mask_all");
    rd(12'h00C, 8'h00, 2'd0, "all_pending");
    step(1'b1, 1'b1, 12'h008, 32'h0000_000F, 8'h00, 2'd1, "reset_with_wr");
    rd(12'h00C, 8'h00, 2'd0, "post_rst_pend");
    rd(12'h008, 8'h00, 2'd0, "post_rst_mask");
    rd(12'h004, 8'h00, 2'd3, "post_rst_ptr");
    rd(12'h010, 8'h00, 2'd0, "post_rst_err");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), rand_offset(),
           $urandom(), rand_status(), 2'($urandom_range(0, 3)), "random");
    end

    chk_en = 1'b0;
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
